rf_wport_sched: RTL and testbench

//  Scheduler for the single register-file write port (a3/wd3/WriteEn). After reset it walks
//  x1..x31 writing zero, because the regfile array itself has no reset. In RUN it shares the

---
 rtl/rf_wport_sched_if.sv | 37 +++
 rtl/rf_wport_sched.sv | 92 +++++++++
 tb/tb_rf_wport_sched.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_sched_if.sv
// Signal bundle between the pipeline/MDU side and the register-file write-port scheduler.
// Handshake: an MDU result transfers on any cycle with mdu_valid & mdu_ready_o high; while
// mdu_valid=1 and mdu_ready_o=0 the producer holds mdu_rd/mdu_data stable and keeps valid up.
interface rf_wport_sched_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            mdu_valid;
  logic [AW-1:0]   mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready_o;
  logic            stall_req_o;
  logic            busy_o;
  logic [AW-1:0]   rf_a3_o;
  logic [XLEN-1:0] rf_wd3_o;
  logic            rf_we_o;
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] rd1_o;
  logic [XLEN-1:0] rd2_o;
  logic            dbg_state;

  modport master (
    output wb_en, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, a1, a2, rf_rd1, rf_rd2,
    input  mdu_ready_o, stall_req_o, busy_o, rf_a3_o, rf_wd3_o, rf_we_o, rd1_o, rd2_o, dbg_state
  );

  modport slave (
    input  wb_en, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, a1, a2, rf_rd1, rf_rd2,
    output mdu_ready_o, stall_req_o, busy_o, rf_a3_o, rf_wd3_o, rf_we_o, rd1_o, rd2_o, dbg_state
  );
endinterface

// File: rtl/rf_wport_sched.sv
// Register-file write-port scheduler: zero-fills x1..x(NREG-1) after reset, then arbitrates
// WB (fixed priority) against the MDU with a starvation stall request, plus read bypass.
module rf_wport_sched #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  rf_wport_sched_if.slave   bus
);
  localparam int NREG = 2 ** AW;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   clr_idx, clr_idx_d;
  logic [CW-1:0]   starve_cnt, starve_cnt_d;
  logic            stall_q, stall_d;
  logic            wb_grant, mdu_grant, busy;
  logic            we, we_g;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_idx    <= AW'(1);
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      state      <= state_d;
      clr_idx    <= clr_idx_d;
      starve_cnt <= starve_cnt_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    state_d      = state;
    clr_idx_d    = clr_idx;
    starve_cnt_d = starve_cnt;
    stall_d      = stall_q;
    wb_grant     = 1'b0;
    mdu_grant    = 1'b0;
    busy         = 1'b1;
    we           = 1'b0;
    a3           = '0;
    wd3          = '0;
    case (state)
      CLEAR: begin
        we        = 1'b1;
        a3        = clr_idx;
        clr_idx_d = clr_idx + AW'(1);
        if (clr_idx == AW'(NREG - 1)) state_d = RUN;
      end
      RUN: begin
        busy = 1'b0;
        if (bus.wb_en) begin
          wb_grant = 1'b1;
          a3       = bus.wb_rd;
          wd3      = bus.wb_data;
        end else if (bus.mdu_valid) begin
          mdu_grant = 1'b1;
          a3        = bus.mdu_rd;
          wd3       = bus.mdu_data;
        end
        // x0 is hardwired zero: the grant still happens, only the write enable is dropped.
        we = (wb_grant | mdu_grant) & (a3 != '0);
        if (mdu_grant || !bus.mdu_valid) starve_cnt_d = '0;
        else if (starve_cnt != CW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt + CW'(1);
        // Looking at the next count lets the request rise right after the LIMIT-th lost cycle.
        stall_d = mdu_grant ? 1'b0 : (stall_q | (starve_cnt_d == CW'(STARVE_LIMIT)));
      end
      default: state_d = CLEAR;
    endcase
  end

  assign we_g = we & ~rst;

  assign bus.rf_we_o     = we_g;
  assign bus.rf_a3_o     = a3;
  assign bus.rf_wd3_o    = wd3;
  assign bus.mdu_ready_o = mdu_grant & ~rst;
  assign bus.busy_o      = busy | rst;
  assign bus.stall_req_o = stall_q;
  assign bus.dbg_state   = state;

  assign bus.rd1_o = (we_g && bus.a1 == a3 && bus.a1 != '0) ? wd3 : bus.rf_rd1;
  assign bus.rd2_o = (we_g && bus.a2 == a3 && bus.a2 != '0) ? wd3 : bus.rf_rd2;
endmodule

// File: tb/tb_rf_wport_sched.sv
// Randomized bench for rf_wport_sched against a cycle-level behavioural model of the
// write-port rules, with a write scoreboard and per-cycle output checks.
module tb_rf_wport_sched;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;
  localparam int NREG  = 2 ** AW;
  localparam int W     = AW + XLEN;

  logic clk;
  logic rst;
  rf_wport_sched_if #(.XLEN(XLEN), .AW(AW)) bus ();

  rf_wport_sched #(.XLEN(XLEN), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model state
  bit m_clearing;
  int m_idx;
  int m_run;
  bit m_stall;
  bit e_busy, e_we, e_ready, e_grant;
  logic [AW-1:0]   e_a3;
  logic [XLEN-1:0] e_wd3, e_rd1, e_rd2;

  // MDU producer state for the random phase
  bit              pend;
  logic [AW-1:0]   p_rd;
  logic [XLEN-1:0] p_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    e_busy = 1'b1; e_we = 1'b0; e_ready = 1'b0; e_grant = 1'b0;
    e_a3 = '0; e_wd3 = '0;
    if (!rst) begin
      if (m_clearing) begin
        e_we = 1'b1;
        e_a3 = AW'(m_idx);
      end else begin
        e_busy = 1'b0;
        if (bus.wb_en) begin
          e_grant = 1'b1; e_a3 = bus.wb_rd; e_wd3 = bus.wb_data;
        end else if (bus.mdu_valid) begin
          e_grant = 1'b1; e_ready = 1'b1; e_a3 = bus.mdu_rd; e_wd3 = bus.mdu_data;
        end
        e_we = e_grant && (e_a3 != 0);
      end
    end
    e_rd1 = (e_we && bus.a1 == e_a3 && bus.a1 != 0) ? e_wd3 : bus.rf_rd1;
    e_rd2 = (e_we && bus.a2 == e_a3 && bus.a2 != 0) ? e_wd3 : bus.rf_rd2;
  endtask

  task automatic model_tick();
    if (rst) begin
      m_clearing = 1'b1; m_idx = 1; m_run = 0; m_stall = 1'b0;
    end else if (m_clearing) begin
      if (m_idx == NREG - 1) m_clearing = 1'b0;
      else m_idx++;
    end else if (e_ready) begin
      m_run = 0; m_stall = 1'b0;
    end else if (bus.mdu_valid) begin
      m_run++;
      if (m_run >= LIMIT) m_stall = 1'b1;
    end else begin
      m_run = 0;
    end
  endtask

  // One clock: entered just after a negedge with inputs already driven.
  task automatic cycle();
    logic [W-1:0] exp_w;
    #1;
    model_eval();
    check_eq("busy", bus.busy_o, e_busy);
    check_eq("we", bus.rf_we_o, e_we);
    check_eq("mdu_ready", bus.mdu_ready_o, e_ready);
    check_eq("rd1", bus.rd1_o, e_rd1);
    check_eq("rd2", bus.rd2_o, e_rd2);
    if (!rst) check_eq("stall_req", bus.stall_req_o, m_stall);
    if (e_we) exp_q.push_back({e_a3, e_wd3});
    if (bus.rf_we_o === 1'b1) begin
      check_eq("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check_eq("sb_write", {bus.rf_a3_o, bus.rf_wd3_o}, exp_w);
      end
    end
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    bus.a1 = '0; bus.a2 = '0; bus.rf_rd1 = '0; bus.rf_rd2 = '0;
  endtask

  task automatic rand_reads();
    bus.a1 = ($urandom_range(0, 2) == 0) ? bus.wb_rd : AW'($urandom_range(0, NREG - 1));
    bus.a2 = ($urandom_range(0, 2) == 0) ? bus.mdu_rd : AW'($urandom_range(0, NREG - 1));
    bus.rf_rd1 = $urandom;
    bus.rf_rd2 = $urandom;
  endtask

  task automatic rand_wb(input bit allow);
    bus.wb_en   = allow ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.wb_rd   = AW'($urandom_range(0, NREG - 1));
    bus.wb_data = $urandom;
  endtask

  // Clear walk with random (ignored) WB traffic and no MDU result.
  task automatic run_clear();
    bus.mdu_valid = 1'b0;
    for (int i = 0; i < NREG - 1; i++) begin
      rand_wb(1'b1); rand_reads(); cycle();
    end
  endtask

  task automatic random_phase(input int n);
    pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        p_rd = AW'($urandom_range(0, NREG - 1));
        p_data = $urandom;
      end
      bus.mdu_valid = pend; bus.mdu_rd = p_rd; bus.mdu_data = p_data;
      // Honour the stall request, with the odd violation to show WB still wins.
      rand_wb(!m_stall || $urandom_range(0, 15) == 0);
      if (m_stall && bus.wb_en) bus.wb_en = 1'b1;
      rand_reads();
      cycle();
      if (e_ready) pend = 1'b0;
    end
    bus.mdu_valid = 1'b0; bus.wb_en = 1'b0;
  endtask

  initial begin
    idle();
    p_rd = '0; p_data = '0; pend = 1'b0;
    m_clearing = 1'b1; m_idx = 1; m_run = 0; m_stall = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    repeat (2) cycle();
    rst = 1'b0;

    // Clear walk, then first RUN cycle idle.
    run_clear();
    idle(); cycle();

    // WB beats MDU, MDU takes the next free cycle.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h0000CAFE;
    bus.a1 = 5'd5; bus.a2 = 5'd7;
    cycle();
    bus.wb_en = 1'b0;
    cycle();
    idle(); cycle();

    // Starvation: stall request after LIMIT lost cycles, released after grant.
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h00000999;
    for (int i = 0; i < 5; i++) begin
      bus.wb_en = 1'b1; bus.wb_rd = AW'($urandom_range(1, NREG - 1)); bus.wb_data = $urandom;
      cycle();
    end
    check_eq("stall_after_limit", bus.stall_req_o, 1);
    bus.wb_en = 1'b0;
    cycle();
    bus.mdu_valid = 1'b0;
    cycle();

    // Writes to x0.
    bus.wb_en = 1'b1; bus.wb_rd = '0; bus.wb_data = 32'h11111111;
    cycle();
    bus.wb_en = 1'b0; bus.mdu_valid = 1'b1; bus.mdu_rd = '0; bus.mdu_data = 32'h22222222;
    cycle();
    bus.mdu_valid = 1'b0;

    // Bypass hit on read port 1, raw data on port 2, then a1=0.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'h12345678;
    bus.a1 = 5'd3; bus.a2 = 5'd4; bus.rf_rd1 = 32'h55; bus.rf_rd2 = 32'hAA;
    cycle();
    bus.a1 = '0;
    cycle();
    idle();

    random_phase(300);

    // Reset in the middle of the clear walk.
    rst = 1'b1; cycle();
    rst = 1'b0;
    for (int g = 0; g < 40 && !(m_clearing && m_idx == 10); g++) begin
      rand_wb(1'b1); rand_reads(); cycle();
    end
    check_eq("mid_clear_idx", m_idx, 10);
    rst = 1'b1; cycle();
    rst = 1'b0;
    run_clear();
    idle(); cycle();

    // Reset while the stall request is up.
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = $urandom;
      cycle();
    end
    check_eq("stall_before_rst", bus.stall_req_o, 1);
    idle(); rst = 1'b1; cycle();
    rst = 1'b0;
    cycle();
    run_clear();
    idle(); cycle();

    random_phase(200);
    idle(); cycle();

    check_eq("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
